// File: rtl/sobel_edge_engine.sv
// sobel_edge_engine: 3x3 Sobel edge stage on the luma channel with its own line buffers.
// Define SOBEL_STATS_EN to build the per-frame edge-pixel counter.
module sobel_edge_engine #(
  parameter int unsigned DW          = 8,
  parameter int unsigned IMG_HDISP   = 1920,
  parameter int unsigned THRESH_INIT = 48,
  parameter int unsigned COUNT_W     = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               per_frame_vsync,
  input  logic               per_frame_href,
  input  logic               per_frame_clken,
  input  logic [DW-1:0]      per_img_gray,
  input  logic [DW+2:0]      thresh,
  input  logic [1:0]         mode,
  output logic               post_frame_vsync,
  output logic               post_frame_href,
  output logic               post_frame_clken,
  output logic [DW-1:0]      post_img_data,
  output logic               post_img_bit,
  output logic [COUNT_W-1:0] edge_count,
  output logic               edge_count_valid
);
  localparam int unsigned MW = DW + 3;
  localparam int unsigned SW = DW + 2;
  localparam int unsigned AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned CW = $clog2(IMG_HDISP + 1);

  logic                vsync_prev_q, href_prev_q, armed_q, armed_d;
  logic [CW-1:0]       col_q, col_d;
  logic [1:0]          row_q, row_d, row_c;
  logic [MW-1:0]       thresh_q, thresh_d;
  logic [1:0]          mode_q, mode_d;
  logic                vs_rise, hs_fall, in_range, wr_en;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       rd0, rd1;
  logic [DW-1:0]       buf0_mem [IMG_HDISP];
  logic [DW-1:0]       buf1_mem [IMG_HDISP];

  // S0: window columns [left..right], each {bottom, middle, top}
  logic [2:0][2:0][DW-1:0] win_q, win_d;
  logic                v0_q, v0_d, ovr0_q, ovr0_d;
  logic [MW-1:0]       thr0_q;
  logic [1:0]          mode0_q;
  // S1
  logic [SW-1:0]       sum_l_q, sum_l_d, sum_r_q, sum_r_d, sum_t_q, sum_t_d, sum_b_q, sum_b_d;
  logic [DW-1:0]       ctr1_q;
  logic                v1_q, ovr1_q;
  logic [MW-1:0]       thr1_q;
  logic [1:0]          mode1_q;
  // S2
  logic [MW-1:0]       gx, gy;
  logic [SW-1:0]       abs_x_q, abs_x_d, abs_y_q, abs_y_d;
  logic [DW-1:0]       ctr2_q;
  logic                v2_q, ovr2_q;
  logic [MW-1:0]       thr2_q;
  logic [1:0]          mode2_q;
  // S3
  logic [MW-1:0]       mag;
  logic                edge_hit;
  logic [DW-1:0]       sat, data_q, data_d;
  logic                bit_q, bit_d;
  logic [3:0][2:0]     sync_q;

  // Frame registers, position tracking and line-buffer read
  always_comb begin
    vs_rise  = per_frame_vsync & ~vsync_prev_q;
    hs_fall  = ~per_frame_href & href_prev_q;
    thresh_d = vs_rise ? thresh : thresh_q;
    mode_d   = vs_rise ? mode : mode_q;
    armed_d  = armed_q | vs_rise;
    row_c    = vs_rise ? 2'd0 : row_q;
    in_range = col_q < CW'(IMG_HDISP);
    wr_en    = per_frame_clken & in_range;
    addr     = AW'(col_q);
    rd0      = in_range ? buf0_mem[addr] : '0;
    rd1      = in_range ? buf1_mem[addr] : '0;
    col_d    = col_q;
    row_d    = row_c;
    if (hs_fall) begin
      col_d = '0;
      if (row_c != 2'd2) row_d = row_c + 2'd1;
    end else if (wr_en) begin
      col_d = col_q + CW'(1);
    end
    win_d  = win_q;
    v0_d   = v0_q;
    ovr0_d = ovr0_q;
    if (per_frame_clken) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = {per_img_gray, rd0, rd1};
      v0_d     = armed_d & (row_c == 2'd2) & (col_q >= CW'(2));
      ovr0_d   = ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf0_mem[addr] <= per_img_gray;
      buf1_mem[addr] <= rd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      thresh_q     <= MW'(THRESH_INIT);
      mode_q       <= 2'd1;
      win_q        <= '0;
      v0_q         <= 1'b0;
      ovr0_q       <= 1'b0;
      thr0_q       <= '0;
      mode0_q      <= '0;
      sync_q       <= '0;
    end else begin
      vsync_prev_q <= per_frame_vsync;
      href_prev_q  <= per_frame_href;
      armed_q      <= armed_d;
      col_q        <= col_d;
      row_q        <= row_d;
      thresh_q     <= thresh_d;
      mode_q       <= mode_d;
      win_q        <= win_d;
      v0_q         <= v0_d;
      ovr0_q       <= ovr0_d;
      thr0_q       <= thresh_d;
      mode0_q      <= mode_d;
      sync_q       <= {sync_q[2:0], {per_frame_vsync, per_frame_href, per_frame_clken}};
    end
  end

  // S1 weighted column/row sums, S2 gradients and absolute values
  always_comb begin
    sum_l_d = SW'(win_q[0][0]) + (SW'(win_q[0][1]) << 1) + SW'(win_q[0][2]);
    sum_r_d = SW'(win_q[2][0]) + (SW'(win_q[2][1]) << 1) + SW'(win_q[2][2]);
    sum_t_d = SW'(win_q[0][0]) + (SW'(win_q[1][0]) << 1) + SW'(win_q[2][0]);
    sum_b_d = SW'(win_q[0][2]) + (SW'(win_q[1][2]) << 1) + SW'(win_q[2][2]);
    gx      = MW'(sum_r_q) - MW'(sum_l_q);
    gy      = MW'(sum_b_q) - MW'(sum_t_q);
    abs_x_d = gx[MW-1] ? SW'(-gx) : SW'(gx);
    abs_y_d = gy[MW-1] ? SW'(-gy) : SW'(gy);
  end

  // S3 magnitude, threshold and output mode mux
  always_comb begin
    mag      = MW'(abs_x_q) + MW'(abs_y_q);
    edge_hit = v2_q & (mag > thr2_q);
    sat      = (|mag[MW-1:DW]) ? '1 : mag[DW-1:0];
    data_d   = '0;
    bit_d    = 1'b0;
    if (sync_q[2][0] & ~ovr2_q) begin
      bit_d = edge_hit;
      case (mode2_q)
        2'd0:    data_d = v2_q ? ctr2_q : '0;
        2'd1:    data_d = edge_hit ? '1 : '0;
        2'd2:    data_d = v2_q ? sat : '0;
        default: data_d = edge_hit ? '0 : '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_l_q <= '0; sum_r_q <= '0; sum_t_q <= '0; sum_b_q <= '0;
      ctr1_q  <= '0; v1_q <= 1'b0; ovr1_q <= 1'b0; thr1_q <= '0; mode1_q <= '0;
      abs_x_q <= '0; abs_y_q <= '0;
      ctr2_q  <= '0; v2_q <= 1'b0; ovr2_q <= 1'b0; thr2_q <= '0; mode2_q <= '0;
      data_q  <= '0; bit_q <= 1'b0;
    end else begin
      sum_l_q <= sum_l_d; sum_r_q <= sum_r_d; sum_t_q <= sum_t_d; sum_b_q <= sum_b_d;
      ctr1_q  <= win_q[1][1]; v1_q <= v0_q; ovr1_q <= ovr0_q; thr1_q <= thr0_q; mode1_q <= mode0_q;
      abs_x_q <= abs_x_d; abs_y_q <= abs_y_d;
      ctr2_q  <= ctr1_q; v2_q <= v1_q; ovr2_q <= ovr1_q; thr2_q <= thr1_q; mode2_q <= mode1_q;
      data_q  <= data_d; bit_q <= bit_d;
    end
  end

  assign post_frame_vsync = sync_q[3][2];
  assign post_frame_href  = sync_q[3][1];
  assign post_frame_clken = sync_q[3][0];
  assign post_img_data    = data_q;
  assign post_img_bit     = bit_q;

`ifdef SOBEL_STATS_EN
  logic [COUNT_W-1:0] cnt_q, cnt_d, ec_q, ec_d;
  logic               ecv_q, ecv_d, pvs_prev_q, inc;

  // Running count; an increment coinciding with the frame-end copy belongs to the next frame
  always_comb begin
    inc   = post_frame_clken & post_img_bit;
    cnt_d = cnt_q;
    ec_d  = ec_q;
    ecv_d = 1'b0;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + COUNT_W'(1);
    if (pvs_prev_q & ~post_frame_vsync) begin
      ec_d  = cnt_q;
      ecv_d = 1'b1;
      cnt_d = COUNT_W'(inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ec_q       <= '0;
      ecv_q      <= 1'b0;
      pvs_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ec_q       <= ec_d;
      ecv_q      <= ecv_d;
      pvs_prev_q <= post_frame_vsync;
    end
  end

  assign edge_count       = ec_q;
  assign edge_count_valid = ecv_q;
`else
  assign edge_count       = '0;
  assign edge_count_valid = 1'b0;
`endif

endmodule
